// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The checksum_err_o signal exists only when INST_LOADER_CHECKSUM_EN is defined.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
);
  logic              start_i;
  logic [ADDR_W:0]   word_count_i;
  logic [7:0]        byte_data_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [WORD_W-1:0] wr_data_o;
  logic              busy_o;
  logic              cpu_hold_o;
  logic              done_o;
`ifdef INST_LOADER_CHECKSUM_EN
  logic              checksum_err_o;
`endif

  // The loader itself
  modport slave (
`ifdef INST_LOADER_CHECKSUM_EN
    output checksum_err_o,
`endif
    input  start_i, word_count_i, byte_data_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
    output busy_o, cpu_hold_o, done_o
  );

  modport master (
`ifdef INST_LOADER_CHECKSUM_EN
    input  checksum_err_o,
`endif
    output start_i, word_count_i, byte_data_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
    input  busy_o, cpu_hold_o, done_o
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory writer: packs a little-endian byte stream into words.
// Optional trailing modulo-256 checksum byte enabled by INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int WORD_W = 32
) (
  input logic               clk,
  input logic               rst,
  inst_mem_loader_if.slave  bus
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
  localparam state_t LAST_STATE = CHECK;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam state_t LAST_STATE = DONE;
`endif

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [1:0]        lane;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   n_clamped;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] pack;
  logic              byte_fire;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
  logic              checksum_err;
`endif

  // Clamping to DEPTH keeps every write inside the memory without address wrap
  assign n_clamped    = (bus.word_count_i > DEPTH_C) ? DEPTH_C : bus.word_count_i;
  assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);
  assign byte_fire    = bus.byte_valid_i && (state == RECV);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start_i) state_next = (n_clamped == '0) ? LAST_STATE : RECV;
      RECV:  if (byte_fire && lane == 2'd3) state_next = WRITE;
      WRITE: state_next = (word_cnt_inc == n_words) ? LAST_STATE : RECV;
`ifdef INST_LOADER_CHECKSUM_EN
      CHECK: if (bus.byte_valid_i) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane     <= '0;
      word_cnt <= '0;
      n_words  <= '0;
      addr     <= '0;
      pack     <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum          <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.start_i) begin
          n_words  <= n_clamped;
          word_cnt <= '0;
          addr     <= '0;
          lane     <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum          <= '0;
          checksum_err <= 1'b0;
`endif
        end
        RECV: if (byte_fire) begin
          pack[{lane, 3'b000} +: 8] <= bus.byte_data_i;
          lane                      <= lane + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          sum <= sum + bus.byte_data_i;
`endif
        end
        WRITE: begin
          addr     <= addr + ADDR_W'(1);
          word_cnt <= word_cnt_inc;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        CHECK: if (bus.byte_valid_i && bus.byte_data_i != sum) checksum_err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.wr_en_o    = (state == WRITE);
  assign bus.wr_addr_o  = addr;
  assign bus.wr_data_o  = pack;
  assign bus.busy_o     = (state == RECV) || (state == WRITE);
  assign bus.cpu_hold_o = bus.busy_o;
  assign bus.done_o     = (state == DONE);
`ifdef INST_LOADER_CHECKSUM_EN
  assign bus.byte_ready_o   = (state == RECV) || (state == CHECK);
  assign bus.checksum_err_o = checksum_err;
`else
  assign bus.byte_ready_o   = (state == RECV);
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (small DEPTH to exercise clamping).
// Honours INST_LOADER_CHECKSUM_EN by appending the checksum byte to each load.
module tb_inst_mem_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 6;
  localparam int WORD_W = 32;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_mem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [ADDR_W-1:0] log_addr [0:31];
  logic [31:0]       log_data [0:31];
  logic [7:0]        stim     [0:31];

  // Write monitor: captures every strobe mid-cycle and checks no byte is offered then
  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      if (wr_count < 32) begin
        log_addr[wr_count] = bus.wr_addr_o;
        log_data[wr_count] = bus.wr_data_o;
      end
      wr_count++;
      checks++;
      assert (bus.byte_ready_o === 1'b0) else begin
        errors++;
        $error("[TB] FAIL ready_in_write observed=%b expected=0", bus.byte_ready_o);
      end
    end
    if (bus.done_o === 1'b1) done_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [ADDR_W:0] count,
                               input logic [7:0] data, input logic valid);
    bus.start_i      = start;
    bus.word_count_i = count;
    bus.byte_data_i  = data;
    bus.byte_valid_i = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.byte_ready_o), 0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en_o), 0);
    checkOutput({tag, "_addr"},  32'(bus.wr_addr_o), 0);
    checkOutput({tag, "_data"},  bus.wr_data_o, 0);
    checkOutput({tag, "_busy"},  32'(bus.busy_o), 0);
    checkOutput({tag, "_hold"},  32'(bus.cpu_hold_o), 0);
    checkOutput({tag, "_done"},  32'(bus.done_o), 0);
`ifdef INST_LOADER_CHECKSUM_EN
    checkOutput({tag, "_cksum"}, 32'(bus.checksum_err_o), 0);
`endif
  endtask

  // Start a load, stream stim[0..nbytes-1] honouring byte_ready_o, wait for done_o
  task automatic runLoad(input logic [ADDR_W:0] count, input int nbytes, input bit toggle);
    int wait_cnt;
    wr_count   = 0;
    done_count = 0;
    applyStimulus(1'b1, count, 8'h00, 1'b0);
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (toggle && i > 0) begin
        bus.byte_valid_i = 1'b0;
        step();
      end
      bus.byte_data_i  = stim[i];
      bus.byte_valid_i = 1'b1;
      wait_cnt = 0;
      while (bus.byte_ready_o !== 1'b1 && wait_cnt < 20) begin
        step();
        wait_cnt++;
      end
      if (wait_cnt >= 20) checkOutput("ready_timeout", 32'(bus.byte_ready_o), 1);
      step();
    end
    bus.byte_valid_i = 1'b0;
    wait_cnt = 0;
    while (done_count == 0 && wait_cnt < 40) begin
      step();
      wait_cnt++;
    end
    step();
    step();
    checkOutput("done_once", 32'(done_count), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, '0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;
    checkIdle("reset");

    // Two words, valid held high, exact cycle placement of both writes
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
    stim[4] = 8'h93; stim[5] = 8'h80; stim[6] = 8'h00; stim[7] = 8'h00;
    stim[8] = 8'h26;
    wr_count = 0;
    done_count = 0;
    applyStimulus(1'b1, 2, 8'h00, 1'b0);
    step();
    checkOutput("t1_busy", 32'(bus.busy_o), 1);
    checkOutput("t1_hold", 32'(bus.cpu_hold_o), 1);
    checkOutput("t1_ready", 32'(bus.byte_ready_o), 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 7, stim[k], 1'b1);
      step();
    end
    checkOutput("t1_w0_en", 32'(bus.wr_en_o), 1);
    checkOutput("t1_w0_addr", 32'(bus.wr_addr_o), 0);
    checkOutput("t1_w0_data", bus.wr_data_o, 32'h0000_0013);
    checkOutput("t1_w0_hold", 32'(bus.cpu_hold_o), 1);
    applyStimulus(1'b0, 7, stim[4], 1'b1);
    step();
    checkOutput("t1_after_w0_en", 32'(bus.wr_en_o), 0);
    for (int k = 4; k < 8; k++) begin
      applyStimulus(1'b0, 7, stim[k], 1'b1);
      step();
    end
    checkOutput("t1_w1_en", 32'(bus.wr_en_o), 1);
    checkOutput("t1_w1_addr", 32'(bus.wr_addr_o), 1);
    checkOutput("t1_w1_data", bus.wr_data_o, 32'h0000_8093);
    checkOutput("t1_w1_hold", 32'(bus.cpu_hold_o), 1);
    bus.byte_valid_i = 1'b0;
    step();
`ifdef INST_LOADER_CHECKSUM_EN
    applyStimulus(1'b0, 7, stim[8], 1'b1);
    checkOutput("t1_check_ready", 32'(bus.byte_ready_o), 1);
    step();
    bus.byte_valid_i = 1'b0;
`endif
    checkOutput("t1_done", 32'(bus.done_o), 1);
    checkOutput("t1_done_busy", 32'(bus.busy_o), 0);
    checkOutput("t1_done_hold", 32'(bus.cpu_hold_o), 0);
    step();
    checkOutput("t1_done_clear", 32'(bus.done_o), 0);
    checkOutput("t1_wr_count", 32'(wr_count), 2);
    checkOutput("t1_done_count", 32'(done_count), 1);

    // Same load with valid toggling
    runLoad(2, 8 + CK, 1'b1);
    checkOutput("t2_wr_count", 32'(wr_count), 2);
    checkOutput("t2_addr0", 32'(log_addr[0]), 0);
    checkOutput("t2_data0", log_data[0], 32'h0000_0013);
    checkOutput("t2_addr1", 32'(log_addr[1]), 1);
    checkOutput("t2_data1", log_data[1], 32'h0000_8093);

    // Zero-word load
    wr_count = 0;
    done_count = 0;
    applyStimulus(1'b1, 0, 8'h00, 1'b0);
    step();
    bus.start_i = 1'b0;
    checkOutput("t3_busy", 32'(bus.busy_o), 0);
`ifdef INST_LOADER_CHECKSUM_EN
    checkOutput("t3_check_ready", 32'(bus.byte_ready_o), 1);
    applyStimulus(1'b0, 0, 8'h00, 1'b1);
    step();
    bus.byte_valid_i = 1'b0;
`endif
    checkOutput("t3_done", 32'(bus.done_o), 1);
    step();
    checkOutput("t3_done_clear", 32'(bus.done_o), 0);
    checkOutput("t3_wr_count", 32'(wr_count), 0);

    // Oversized count clamps to DEPTH writes
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < 4; k++)
        stim[4*w+k] = 8'(16*w + k);
    stim[4*DEPTH] = 8'hE4;
    runLoad(DEPTH + 5, 4*DEPTH + CK, 1'b0);
    checkOutput("t4_wr_count", 32'(wr_count), DEPTH);
    for (int w = 0; w < DEPTH; w++) begin
      checkOutput($sformatf("t4_addr%0d", w), 32'(log_addr[w]), 32'(w));
      checkOutput($sformatf("t4_data%0d", w), log_data[w],
                  {8'(16*w+3), 8'(16*w+2), 8'(16*w+1), 8'(16*w)});
    end

    // Reset after 6 bytes of a 3-word load
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
    stim[4] = 8'h93; stim[5] = 8'h80;
    applyStimulus(1'b1, 3, 8'h00, 1'b0);
    step();
    bus.start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 3, stim[k], 1'b1);
      step();
    end
    step();
    for (int k = 4; k < 6; k++) begin
      applyStimulus(1'b0, 3, stim[k], 1'b1);
      step();
    end
    wr_count = 0;
    done_count = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 3, 8'h55, 1'b1);
    step();
    rst = 1'b0;
    checkIdle("midload_reset");
    for (int c = 0; c < 8; c++) step();
    bus.byte_valid_i = 1'b0;
    checkOutput("t5_no_writes", 32'(wr_count), 0);
    checkOutput("t5_no_done", 32'(done_count), 0);
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE; stim[4] = 8'h38;
    runLoad(1, 4 + CK, 1'b0);
    checkOutput("t5_wr_count", 32'(wr_count), 1);
    checkOutput("t5_addr", 32'(log_addr[0]), 0);
    checkOutput("t5_data", log_data[0], 32'hDEAD_BEEF);

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum good then bad
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD; stim[4] = 8'h0E;
    runLoad(1, 5, 1'b0);
    checkOutput("t6_cksum_ok", 32'(bus.checksum_err_o), 0);
    checkOutput("t6_data_ok", log_data[0], 32'hDDCC_BBAA);
    stim[4] = 8'h0F;
    runLoad(1, 5, 1'b0);
    checkOutput("t6_cksum_bad", 32'(bus.checksum_err_o), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory; it is the write-side counterpart of the read-only fetch port.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or debug bridge.
- Packs every four bytes little-endian into one DATA_WIDTH word and drives a single-cycle write into consecutive instruction-memory words starting at word address 0.
- Holds the core in reset (cpu_hold_o) from start until the load completes.

Parameters:
- ADDR_W, default INST_MEM_ADDR_WIDTH: word-address width of the instruction memory.
- DEPTH, default INST_MEM_DEPTH: number of words in the instruction memory.
- WORD_W, default DATA_WIDTH (32): instruction word width. Must equal 32.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  one-cycle request to begin a load
- word_count_i  input  ADDR_W+1  number of words to load; sampled when start_i is accepted
- byte_data_i  input  8  stream byte
- byte_valid_i  input  1  byte_data_i is valid
- byte_ready_o  output  1  loader can accept a byte
- wr_en_o  output  1  instruction-memory write strobe
- wr_addr_o  output  ADDR_W  instruction-memory word address
- wr_data_o  output  WORD_W  instruction-memory write data
- busy_o  output  1  a load is in progress
- cpu_hold_o  output  1  keeps the core in reset; equals busy_o
- done_o  output  1  one-cycle pulse when a load completes

Behaviour:
- Reset: on rst=1 at a clock edge, state goes to IDLE. All outputs are 0. The byte-lane counter, word counter, address register and packing register clear to 0. Reset mid-load abandons the load immediately: no further writes, and done_o does not pulse.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready_o=0.
  - On start_i=1, latch N = min(word_count_i, DEPTH) and go to RECV, or go to DONE directly if N=0.
  - The address register resets to 0 on every accepted start.
- RECV:
  - byte_ready_o=1. A byte is accepted when byte_valid_i && byte_ready_o.
  - Lane k (0..3) stores the accepted byte into bits [8k+7:8k], so the first byte is the LSB.
  - When the 4th byte is accepted, go to WRITE in the next cycle. No bubble between bytes.
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o=current address, wr_data_o=packed word, byte_ready_o=0.
  - Address and written-word count then increment.
  - If the count reaches N, go to DONE; otherwise return to RECV.
- DONE (one cycle): done_o=1, busy_o=0, then go to IDLE.
- busy_o=1 in RECV and WRITE only.
- Latency: the write strobe occurs in the cycle after the 4th byte of a word is accepted. With byte_valid_i held high, each word takes 5 cycles.
- start_i while busy_o=1 is ignored. word_count_i changes after start are ignored.
- Writes never exceed DEPTH-1: clamping N guarantees the address never wraps.
- The address width is ADDR_W. A count of DEPTH requires the ADDR_W+1-bit counter; arithmetic is unsigned.
- wr_addr_o and wr_data_o may hold stale values when wr_en_o=0.

Optional Feature:
- Macro INST_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum_err_o (1 bit, reset 0) and a CHECK state entered after the last WRITE instead of DONE.
  - In CHECK, byte_ready_o=1 and one extra byte is accepted: the 8-bit modulo-256 sum of all data bytes.
  - A mismatch sets checksum_err_o=1 until the next accepted start or reset. Then go to DONE.
  - For N=0 the checksum expected is 0x00, and CHECK is still entered.
- When undefined: no CHECK state, no checksum_err_o port, and the running sum logic is absent.

Test Plan:
- Reset, then start_i with word_count_i=2 and bytes 13,00,00,00,93,80,00,00 with valid held high -> write addr0=0x00000013 and addr1=0x00008093. Writes land at cycles 5 and 10 after the first byte. done_o pulses once. cpu_hold_o is high throughout.
- Same load with byte_valid_i toggling 1-0-1-0 -> identical writes. No byte is lost or duplicated. byte_ready_o=0 during WRITE cycles.
- word_count_i=0 -> no wr_en_o. done_o pulses in the cycle after start. busy_o stays 0.
- word_count_i=DEPTH+5 -> exactly DEPTH writes at addresses 0..DEPTH-1, then done_o.
- Assert rst after 6 bytes of a 3-word load -> all outputs 0 next cycle. No further writes and no done_o. A new start writes from addr 0 again.
- With INST_LOADER_CHECKSUM_EN, 1 word AA,BB,CC,DD then checksum 0x0E -> checksum_err_o=0. Sending 0x0F instead -> checksum_err_o=1, still followed by done_o.
